// File: rtl/cmd_encoder_rr.sv
// cmd_encoder_rr: round-robin packet framer (prefix, addr, source id, length, payload, check byte)
// over a valid/ready byte stream with selectable sum or CRC-8 check byte.
module cmd_encoder_rr #(
  parameter int N_SRC = 4,
  parameter logic [7:0] PREFIX = 8'hAA,
  parameter logic [7:0] ADDR = 8'h01,
  parameter int CHK_MODE = 0,
  localparam int SRC_W = N_SRC > 1 ? $clog2(N_SRC) : 1
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic [N_SRC-1:0]   src_en,
  input  logic [N_SRC-1:0]   have_msg_bus,
  input  logic [8*N_SRC-1:0] len_bus,
  input  logic [8*N_SRC-1:0] data_bus,
  output logic [N_SRC-1:0]   rdreq_bus,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               busy,
  output logic [SRC_W-1:0]   cur_src,
  output logic               pkt_done
);
  typedef enum logic [2:0] {IDLE, PRE, ADR, SID, LEN, DAT, CHK} state_t;
  state_t state;
  logic [SRC_W-1:0] ptr, grant;
  logic [7:0] len, cnt, chk, head;
  logic any, xfer;

  function automatic logic [7:0] upd(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r;
    r = c ^ b;
    for (int i = 0; i < 8; i++) r = r[7] ? {r[6:0], 1'b0} ^ 8'h07 : {r[6:0], 1'b0};
    return CHK_MODE != 0 ? r : c + b;
  endfunction

  // Pick the eligible source with the smallest distance past the last grant.
  always_comb begin
    int d, best;
    any = 1'b0;
    grant = ptr;
    best = N_SRC;
    d = 0;
    for (int i = 0; i < N_SRC; i++) begin
      d = i - int'(ptr) - 1;
      if (d < 0) d += N_SRC;
      if (have_msg_bus[i] && src_en[i] && d < best) begin
        best = d;
        grant = SRC_W'(i);
        any = 1'b1;
      end
    end
  end

  assign head = data_bus[8*cur_src +: 8];
  assign tx_valid = state != IDLE;
  assign busy = tx_valid;
  assign xfer = tx_valid & tx_ready;
  assign pkt_done = xfer && state == CHK;
  assign rdreq_bus = (xfer && state == DAT) ? N_SRC'(1) << cur_src : '0;
  assign tx_data = state == PRE ? PREFIX :
                   state == ADR ? ADDR :
                   state == SID ? 8'(cur_src) :
                   state == LEN ? len :
                   state == DAT ? head :
                   state == CHK ? chk : 8'h00;

  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state <= IDLE;
      ptr <= '0;
      cur_src <= '0;
      len <= '0;
      cnt <= '0;
      chk <= '0;
    end else
      case (state)
        IDLE: if (any) begin
          cur_src <= grant;
          len <= len_bus[8*grant +: 8];
          chk <= '0;
          cnt <= '0;
          state <= PRE;
        end
        PRE: if (xfer) state <= ADR;
        ADR: if (xfer) state <= SID;
        SID: if (xfer) state <= LEN;
        LEN: if (xfer) state <= len != 8'd0 ? DAT : CHK;
        DAT: if (xfer) begin
          chk <= upd(chk, head);
          cnt <= cnt + 8'd1;
          if (cnt == len - 8'd1) state <= CHK;
        end
        CHK: if (xfer) begin
          ptr <= cur_src;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_cmd_encoder_rr.sv
// tb_cmd_encoder_rr: frame-level reference model driving a sum-mode and a CRC-mode encoder
// from shared random/directed source FIFOs.
module tb_cmd_encoder_rr;
  localparam int N = 4;
  logic clk = 0, n_rst = 0, tx_ready = 0;
  logic [N-1:0] src_en = '0, have = '0, rd0, rd1;
  logic [8*N-1:0] len_bus = '0, data_bus = '0;
  logic [7:0] txd0, txd1;
  logic v0, v1, b0, b1, pd0, pd1;
  logic [1:0] cs0, cs1;

  always #5 clk = ~clk;

  cmd_encoder_rr #(.N_SRC(N), .CHK_MODE(0)) dut0 (.clk(clk), .n_rst(n_rst), .src_en(src_en),
    .have_msg_bus(have), .len_bus(len_bus), .data_bus(data_bus), .rdreq_bus(rd0), .tx_data(txd0),
    .tx_valid(v0), .tx_ready(tx_ready), .busy(b0), .cur_src(cs0), .pkt_done(pd0));
  cmd_encoder_rr #(.N_SRC(N), .CHK_MODE(1)) dut1 (.clk(clk), .n_rst(n_rst), .src_en(src_en),
    .have_msg_bus(have), .len_bus(len_bus), .data_bus(data_bus), .rdreq_bus(rd1), .tx_data(txd1),
    .tx_valid(v1), .tx_ready(tx_ready), .busy(b1), .cur_src(cs1), .pkt_done(pd1));

  int n_chk = 0, n_fail = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Sources: FIFO contents plus pending message flag/length.
  logic [7:0] q[N][$];
  logic [7:0] mlen[N];
  bit mhave[N];
  // Model: whole frame built at grant time, walked one transferred byte at a time.
  logic [7:0] fr[$];
  logic [7:0] c0, c1, last0, last1;
  bit act = 0;
  int pos, flen, msrc, ptr = 0, pkts = 0, rdy_mode = 0, refill = 0, tick = 0;
  int gr_log[$];

  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] b);
    logic [8:0] v;
    v = {1'b0, c ^ b};
    for (int i = 0; i < 8; i++) v = v[7] ? ((v << 1) ^ 9'h107) : (v << 1);
    return v[7:0];
  endfunction

  task automatic add_msg(input int s, input int l, input bit rnd);
    for (int k = 0; k < l; k++) q[s].push_back(rnd ? 8'($urandom) : 8'(k + 1));
    mlen[s] = 8'(l);
    mhave[s] = 1;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      data_bus[8*i +: 8] = q[i].size() > 0 ? q[i][0] : 8'h00;
      len_bus[8*i +: 8] = mlen[i];
      have[i] = mhave[i];
    end
  endtask

  task automatic cycle();
    drive();
    #1;
    if (!act) begin
      check("idle_valid0", v0, 0);
      check("idle_valid1", v1, 0);
      check("idle_busy", b0, 0);
      check("idle_rdreq0", rd0, 0);
      check("idle_rdreq1", rd1, 0);
      check("idle_done", pd0, 0);
      for (int k = N; k >= 1; k--) begin
        int s;
        s = (ptr + k) % N;
        if (mhave[s] && src_en[s]) msrc = s;
      end
      if (|(have & src_en)) begin
        fr = {8'hAA, 8'h01, 8'(msrc), mlen[msrc]};
        flen = mlen[msrc];
        c0 = 0;
        c1 = 0;
        for (int k = 0; k < flen; k++) begin
          fr.push_back(q[msrc][k]);
          c0 += q[msrc][k];
          c1 = crc8(c1, q[msrc][k]);
        end
        mhave[msrc] = 0;
        act = 1;
        pos = 0;
      end
    end else begin
      bit last, pay;
      last = pos == flen + 4;
      pay = pos >= 4 && !last;
      check("valid0", v0, 1);
      check("valid1", v1, 1);
      check("busy", b0, 1);
      check("cur_src", cs0, msrc);
      check("tx_data0", txd0, last ? c0 : fr[pos]);
      check("tx_data1", txd1, last ? c1 : fr[pos]);
      check("rdreq0", rd0, (pay && tx_ready) ? 32'(1 << msrc) : 0);
      check("rdreq1", rd1, (pay && tx_ready) ? 32'(1 << msrc) : 0);
      check("pkt_done0", pd0, last && tx_ready);
      check("pkt_done1", pd1, last && tx_ready);
      if (tx_ready) begin
        if (pay) void'(q[msrc].pop_front());
        if (last) begin
          act = 0;
          ptr = msrc;
          pkts++;
          gr_log.push_back(int'(cs0));
          last0 = txd0;
          last1 = txd1;
        end
        pos++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step();
    tick++;
    tx_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'(tick) : ($urandom_range(0, 3) != 0);
    if (refill != 0)
      for (int i = 0; i < N; i++)
        if (!mhave[i] && q[i].size() == 0) add_msg(i, refill, 1);
    cycle();
  endtask

  task automatic run_pkts(input int n);
    int target, budget;
    target = pkts + n;
    budget = 0;
    while (pkts < target && budget < 2000) begin
      step();
      budget++;
    end
    if (pkts < target) check("timeout", pkts, target);
  endtask

  task automatic do_reset();
    n_rst = 0;
    #1;
    check("rst_valid", v0, 0);
    check("rst_data", txd0, 0);
    check("rst_rdreq", rd0 | rd1, 0);
    check("rst_busy", b0 | b1, 0);
    check("rst_src", cs0, 0);
    check("rst_done", pd0, 0);
    act = 0;
    ptr = 0;
    for (int i = 0; i < N; i++) begin
      q[i].delete();
      mhave[i] = 0;
    end
    drive();
    @(negedge clk);
    n_rst = 1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      mhave[i] = 0;
      mlen[i] = 0;
    end
    @(negedge clk);
    do_reset();
    src_en = 4'b1111;
    add_msg(2, 3, 0);
    run_pkts(1);
    check("sum_06", last0, 8'h06);
    add_msg(0, 2, 0);
    run_pkts(1);
    check("crc_1b", last1, 8'h1B);
    add_msg(3, 1, 0);
    run_pkts(1);
    check("crc_07", last1, 8'h07);
    add_msg(1, 0, 0);
    run_pkts(1);
    check("zlen_sum", last0, 0);
    check("zlen_crc", last1, 0);
    do_reset();
    gr_log.delete();
    for (int i = 0; i < N; i++) add_msg(i, 1, 1);
    run_pkts(4);
    check("rr_a", gr_log.size() == 4 ? (gr_log[0] << 12) | (gr_log[1] << 8) | (gr_log[2] << 4) | gr_log[3] : -1, 32'h1230);
    src_en = 4'b0101;
    refill = 2;
    gr_log.delete();
    run_pkts(4);
    check("rr_b", gr_log.size() == 4 ? (gr_log[0] << 12) | (gr_log[1] << 8) | (gr_log[2] << 4) | gr_log[3] : -1, 32'h2020);
    refill = 0;
    run_pkts(1);
    src_en = 4'b1111;
    rdy_mode = 1;
    add_msg(3, 4, 1);
    run_pkts(1);
    rdy_mode = 0;
    add_msg(1, 5, 0);
    for (int k = 0; k < 50 && !(act && pos == 6); k++) step();
    check("mid_data_reached", act && pos == 6, 1);
    do_reset();
    add_msg(2, 2, 0);
    run_pkts(1);
    check("post_rst_sum", last0, 8'h03);
    rdy_mode = 2;
    for (int t = 0; t < 4000; t++) begin
      if (t % 97 == 0) src_en = 4'($urandom);
      for (int i = 0; i < N; i++)
        if (!mhave[i] && q[i].size() == 0 && $urandom_range(0, 3) == 0)
          add_msg(i, $urandom_range(0, 4) == 0 ? $urandom_range(0, 40) : $urandom_range(0, 5), 1);
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cmd_encoder_rr.md
Name: cmd_encoder_rr

Overview:
Parametrised packet framer for the host TX byte stream; next generation of the command encoder. Arbitrates round-robin among N_SRC message sources with a per-source enable mask. Emits one framed packet per grant: PREFIX, ADDR, source id, length, payload, check byte. Uses a true valid/ready byte handshake sustaining 1 byte/cycle, zero-length packets, and a selectable checksum (8-bit sum or CRC-8).

Parameters:
N_SRC, 4, number of sources (1..256); SRC_W = max(1, clog2(N_SRC))
PREFIX, 8'hAA, first byte of every packet
ADDR, 8'h01, second byte of every packet
CHK_MODE, 0, 0 = 8-bit additive sum mod 256; 1 = CRC-8 (poly 0x07, init 0x00, MSB-first, no reflection/xor-out)

Ports:
clk  in  1  clock
n_rst  in  1  asynchronous active-low reset
src_en  in  N_SRC  per-source arbitration enable
have_msg_bus  in  N_SRC  source i holds a complete message
len_bus  in  8*N_SRC  payload length of source i (bytes, 0..255)
data_bus  in  8*N_SRC  show-ahead FIFO head byte of source i
rdreq_bus  out  N_SRC  pop strobe, one-hot on granted source
tx_data  out  8  outgoing byte
tx_valid  out  1  tx_data valid
tx_ready  in  1  sink accepts byte
busy  out  1  packet in progress (state != IDLE)
cur_src  out  SRC_W  granted source index
pkt_done  out  1  one-cycle pulse on check-byte handshake

Behaviour:
- Reset (n_rst low, async): state IDLE, tx_valid 0, tx_data 0, rdreq_bus 0, busy 0, cur_src 0, pkt_done 0, RR pointer 0, checksum 0. Mid-packet reset abandons the frame; no further pops.
- Handshake: byte transfers when tx_valid & tx_ready. While tx_valid & !tx_ready, tx_data and state hold. tx_valid never drops until transfer.
- States: IDLE, PREFIX, ADDR, SRC, LEN, DATA, CHK.
- IDLE: eligible = have_msg_bus & src_en. If any, grant the first eligible index searching from (last_grant+1) mod N_SRC upward with wrap; latch cur_src, len, clear checksum, go PREFIX. Else stay.
- PREFIX/ADDR/SRC/LEN: tx_valid = 1, tx_data = PREFIX / ADDR / zero-extended cur_src / latched len. Advance on transfer. LEN goes to DATA if len != 0, else CHK.
- DATA: tx_data = data_bus[8*cur_src +: 8] (combinational from FIFO head). rdreq_bus[cur_src] = tx_valid & tx_ready & (state == DATA), in the same cycle as the transfer, so the next head is valid the following cycle. Checksum updates with each transferred byte. Data counter increments per transfer. After the len-th transfer, go CHK.
- CHK: tx_data = checksum (0x00 for len = 0 in both modes). On transfer: pkt_done = 1 for one cycle, RR pointer = cur_src, go IDLE.
- Throughput: with tx_ready held high, a packet of L bytes occupies L+5 consecutive valid cycles. At least one IDLE cycle separates packets. Grant to first tx_valid takes 1 cycle.
- have_msg_bus, src_en and len_bus are ignored after grant. The source must hold len bytes in its FIFO while have_msg is asserted.
- Exactly len pops per packet; rdreq_bus is never asserted outside DATA.
- N_SRC = 1: pointer wraps to self and the source id byte is 0x00.

Test Plan:
- Single packet, CHK_MODE 0, src 2 has len 3, data 01 02 03, tx_ready = 1 -> tx: AA 01 02 03 01 02 03 06 on 8 consecutive valid cycles; 3 rdreq pulses on bit 2; pkt_done with byte 06.
- CHK_MODE 1, len 2, data 01 02 -> check byte 0x1B; len 1, data 01 -> 0x07.
- Zero length, src 1 -> AA 01 01 00 00, no rdreq pulses.
- Round-robin: all 4 sources with messages, src_en = 1111, pointer 0 -> grant order 1,2,3,0. With src_en = 0101 -> grants 2,0,2,0 only.
- Backpressure: tx_ready toggles 1/0 during a len-4 packet -> tx_data stable while stalled, payload order and checksum intact, exactly 4 pops, none while tx_ready is low.
- Reset asserted in DATA after 2 of 5 bytes -> outputs 0 immediately, returns to IDLE, next packet starts with a clean frame.
